// File: rtl/first_cnn_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : first_cnn_feeder_if
//  Description : Bundle of the frame-buffer write port, the frame start/status
//                handshake and the serial pixel stream toward the 3x3 binary
//                convolution engine.
//                  Row_Wr/Row_Addr/Row_Data : frame-buffer row write
//                  Start                    : request to stream one frame
//                  Busy/Done                : frame status
//                  Din_Valid/Din/Cal_Valid  : pixel stream + calculate strobe
//                  Out_Row/Out_Col          : output-map coordinate
//                master = frame source / engine side, slave = feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface first_cnn_feeder_if;
    logic        Row_Wr;
    logic [5:0]  Row_Addr;
    logic [33:0] Row_Data;
    logic        Start;
    logic        Busy;
    logic        Done;
    logic        Din_Valid;
    logic        Din;
    logic        Cal_Valid;
    logic [4:0]  Out_Row;
    logic [4:0]  Out_Col;

    modport master (
        output Row_Wr, Row_Addr, Row_Data, Start,
        input  Busy, Done, Din_Valid, Din, Cal_Valid, Out_Row, Out_Col
    );

    modport slave (
        input  Row_Wr, Row_Addr, Row_Data, Start,
        output Busy, Done, Din_Valid, Din, Cal_Valid, Out_Row, Out_Col
    );
endinterface
`default_nettype wire

// File: rtl/first_cnn_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : first_cnn_feeder
//  Description : Holds a binary frame and streams it row-major, one pixel per
//                cycle, into a 3x3 binary convolution engine. The stream is a
//                34x34 pixel frame followed by one flush beat and one drain
//                cycle. Cal_Valid marks every cycle in which the engine has a
//                complete 3x3 window, tagged with its output-map coordinate.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset (frame buffer retained)
//                bus  - first_cnn_feeder_if.slave (write port, Start,
//                       Busy/Done, Din_Valid/Din/Cal_Valid, Out_Row/Out_Col)
//  Build option: FIRST_CNN_FEEDER_PAD_EN - 32x32 buffer streamed with a
//                one-pixel zero border (stream geometry unchanged).
//  Revision    : 1.0 - initial release
// ============================================================================
module first_cnn_feeder (
    input  logic              clk,
    input  logic              rst,
    first_cnn_feeder_if.slave bus
);

`ifdef FIRST_CNN_FEEDER_PAD_EN
    localparam int unsigned C_BUF = 32;
`else
    localparam int unsigned C_BUF = 34;
`endif

    // Stream geometry: 34 columns, rows 0..33 carry pixels, row 34 col 0 is
    // the flush beat.
    localparam logic [5:0] C_LAST      = 6'd33;
    localparam logic [5:0] C_FLUSH_ROW = 6'd34;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // ------------------------------------------------------------------------
    // Frame buffer (never reset)
    // ------------------------------------------------------------------------
    logic [C_BUF-1:0] fb_q [C_BUF];
    logic [C_BUF-1:0] fb_d [C_BUF];
    logic             wr_ok;

    // ------------------------------------------------------------------------
    // Control / output registers
    // ------------------------------------------------------------------------
    logic [1:0] state_q,     state_d;
    logic [5:0] row_q,       row_d;      // stream position of the pixel on Din
    logic [5:0] col_q,       col_d;
    logic       busy_q,      busy_d;
    logic       done_q,      done_d;
    logic       din_valid_q, din_valid_d;
    logic       din_q,       din_d;

    // Window-complete flag and its coordinate, delayed by two registers
    logic       win_q,       win_d;
    logic [4:0] win_row_q,   win_row_d;
    logic [4:0] win_col_q,   win_col_d;
    logic       cal_valid_q, cal_valid_d;
    logic [4:0] out_row_q,   out_row_d;
    logic [4:0] out_col_q,   out_col_d;

    // Next stream position and pixel lookup
    logic       col_wrap;
    logic [5:0] col_nx;
    logic [5:0] row_nx;
    logic [5:0] look_row;
    logic [5:0] look_col;
    logic       pix_val;

    // ------------------------------------------------------------------------
    // Frame-buffer write: only while idle and only for rows that exist
    // ------------------------------------------------------------------------
`ifdef FIRST_CNN_FEEDER_PAD_EN
    // Upper two data bits have no storage in the 32-wide buffer.
    logic unused_pad_bits;
    assign unused_pad_bits = ^bus.Row_Data[33:32];

    always_comb begin
        fb_d  = fb_q;
        wr_ok = bus.Row_Wr && !busy_q && (bus.Row_Addr < 6'(C_BUF));
        if (wr_ok) begin
            fb_d[bus.Row_Addr[4:0]] = bus.Row_Data[31:0];
        end
    end
`else
    always_comb begin
        fb_d  = fb_q;
        wr_ok = bus.Row_Wr && !busy_q && (bus.Row_Addr < 6'(C_BUF));
        if (wr_ok) begin
            fb_d[bus.Row_Addr] = bus.Row_Data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        fb_q <= fb_d;
    end

    // ------------------------------------------------------------------------
    // Position of the pixel to be presented next cycle
    // ------------------------------------------------------------------------
    assign col_wrap = (col_q == C_LAST);
    assign col_nx   = col_wrap ? 6'd0 : col_q + 6'd1;
    assign row_nx   = col_wrap ? row_q + 6'd1 : row_q;

    // Leaving IDLE the next pixel is (0,0); while streaming it is the
    // successor of the current one.
    always_comb begin
        look_row = row_nx;
        look_col = col_nx;
        if (state_q == ST_IDLE) begin
            look_row = 6'd0;
            look_col = 6'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Live pixel read from the frame buffer
    // ------------------------------------------------------------------------
`ifdef FIRST_CNN_FEEDER_PAD_EN
    logic [4:0] pad_row;
    logic [4:0] pad_col;

    // Interior stream rows/cols 1..32 map to buffer 0..31; the low five bits
    // minus one give that index (32 wraps to 31).
    assign pad_row = look_row[4:0] - 5'd1;
    assign pad_col = look_col[4:0] - 5'd1;

    always_comb begin
        pix_val = 1'b0;
        if ((look_row >= 6'd1) && (look_row <= 6'd32) &&
            (look_col >= 6'd1) && (look_col <= 6'd32)) begin
            pix_val = fb_q[pad_row][pad_col];
        end
    end
`else
    always_comb begin
        pix_val = 1'b0;
        if (look_row < C_FLUSH_ROW) begin
            pix_val = fb_q[look_row][look_col];
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Frame FSM: IDLE -> STREAM (1156 pixels + flush) -> DRAIN -> IDLE
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        din_valid_d = din_valid_q;
        din_d       = din_q;

        case (state_q)
            ST_IDLE: begin
                busy_d      = 1'b0;
                din_valid_d = 1'b0;
                din_d       = 1'b0;
                if (bus.Start) begin
                    state_d     = ST_STREAM;
                    row_d       = 6'd0;
                    col_d       = 6'd0;
                    busy_d      = 1'b1;
                    din_valid_d = 1'b1;
                    din_d       = pix_val;
                end
            end

            ST_STREAM: begin
                if (row_q == C_FLUSH_ROW) begin
                    // Flush beat just presented; one drain cycle follows.
                    state_d     = ST_DRAIN;
                    din_valid_d = 1'b0;
                    din_d       = 1'b0;
                end else begin
                    // Stepping onto row 34 yields the flush beat (pixel 0).
                    row_d       = row_nx;
                    col_d       = col_nx;
                    din_valid_d = 1'b1;
                    din_d       = pix_val;
                end
            end

            ST_DRAIN: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                din_valid_d = 1'b0;
                din_d       = 1'b0;
            end

            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                din_valid_d = 1'b0;
                din_d       = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Calculate strobe: the pixel on Din completes a 3x3 window when it sits
    // at row>=2, col>=2. The engine needs two more cycles, so the flag and its
    // coordinate ride through two register stages. Coordinates are forced to
    // zero whenever the flag is low so the outputs are zero between strobes.
    // ------------------------------------------------------------------------
    always_comb begin
        win_d     = (state_q == ST_STREAM) && (row_q >= 6'd2) &&
                    (row_q <= C_LAST) && (col_q >= 6'd2);
        win_row_d = 5'd0;
        win_col_d = 5'd0;
        if (win_d) begin
            win_row_d = row_q[4:0] - 5'd2;
            win_col_d = col_q[4:0] - 5'd2;
        end
        cal_valid_d = win_q;
        out_row_d   = win_row_q;
        out_col_d   = win_col_q;
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= 6'd0;
            col_q       <= 6'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            din_valid_q <= 1'b0;
            din_q       <= 1'b0;
            win_q       <= 1'b0;
            win_row_q   <= 5'd0;
            win_col_q   <= 5'd0;
            cal_valid_q <= 1'b0;
            out_row_q   <= 5'd0;
            out_col_q   <= 5'd0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            din_valid_q <= din_valid_d;
            din_q       <= din_d;
            win_q       <= win_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            cal_valid_q <= cal_valid_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Din_Valid = din_valid_q;
    assign bus.Din       = din_q;
    assign bus.Cal_Valid = cal_valid_q;
    assign bus.Out_Row   = out_row_q;
    assign bus.Out_Col   = out_col_q;

endmodule
`default_nettype wire
